move_sequencer: RTL and testbench

//  Steps the player sprite once per game tick, in the direction of the held buttons.

---
 rtl/maze_pkg.sv | 32 +++
 rtl/move_sequencer_corner_addr.sv | 29 ++
 rtl/move_sequencer.sv | 154 +++++++++++++++
 tb/tb_move_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared maze-game constants, direction and sequencer state encodings.
package maze_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int CELL_SHIFT = 4;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_REQ,
        ST_WAIT,
        ST_COMMIT
    } state_t;

    // Buttons are active-low; priority is up > down > left > right.
    function automatic dir_t pickDir(input logic up, input logic down,
                                     input logic left, input logic right);
        if (!up)        return DIR_UP;
        else if (!down) return DIR_DOWN;
        else if (!left) return DIR_LEFT;
        else            return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/move_sequencer_corner_addr.sv
// Maps a candidate sprite position and corner index to the wall-map cell
// containing that corner. k[0] selects the right edge, k[1] the bottom edge.
module corner_addr
    import maze_pkg::*;
#(
    parameter int SIZE = 15
) (
    input  logic [9:0] candX,
    input  logic [8:0] candY,
    input  logic [1:0] k,
    output logic [5:0] cx,
    output logic [4:0] cy
);

    localparam logic [9:0] OFF_X = 10'(SIZE - 1);
    localparam logic [8:0] OFF_Y = 9'(SIZE - 1);

    logic [9:0] px;
    logic [8:0] py;

    // Corner pixel, then drop the in-cell offset bits.
    always_comb begin
        px = candX + (k[0] ? OFF_X : 10'd0);
        py = candY + (k[1] ? OFF_Y : 9'd0);
        cx = 6'(px >> CELL_SHIFT);
        cy = 5'(py >> CELL_SHIFT);
    end

endmodule

// File: rtl/move_sequencer.sv
// Player movement sequencer: on each game tick, tries one STEP in the held
// direction, checks all four sprite corners against the shared wall map, and
// commits the move only if every corner is free. Latches arrival in the goal.
module move_sequencer
    import maze_pkg::*;
#(
    parameter int STEP    = 4,
    parameter int SIZE    = 15,
    parameter int START_X = 30,
    parameter int START_Y = 449,
    parameter int X_MAX   = SCREEN_W - 1 - SIZE,
    parameter int Y_MAX   = SCREEN_H - 1 - SIZE,
    parameter int GOAL_CX = 38,
    parameter int GOAL_CY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic       wall_req,
    output logic [5:0] wall_cx,
    output logic [4:0] wall_cy,
    input  logic       wall_gnt,
    input  logic       wall_valid,
    input  logic       wall_hit,
    output logic [9:0] pos_x,
    output logic [8:0] pos_y,
    output logic       busy,
    output logic       overrun,
    output logic       goal_reached
);

    localparam logic [10:0] STEP_X  = 11'(STEP);
    localparam logic [9:0]  STEP_Y  = 10'(STEP);
    localparam logic [10:0] LIM_X   = 11'(X_MAX);
    localparam logic [9:0]  LIM_Y   = 10'(Y_MAX);
    localparam logic [9:0]  GOAL_X  = 10'(GOAL_CX);
    localparam logic [8:0]  GOAL_Y  = 9'(GOAL_CY);

    state_t      state;
    dir_t        dir;
    logic [1:0]  k;
    logic [9:0]  candX;
    logic [8:0]  candY;
    logic [10:0] nextX;
    logic [9:0]  nextY;
    logic        reject;
    logic        anyBtn;

    assign anyBtn = ~(btn_up & btn_down & btn_left & btn_right);

    // Candidate one bit wider than the position: a subtraction below zero
    // wraps into the top bit and lands above the limit, so a single compare
    // catches both underflow and overflow.
    always_comb begin
        nextX = {1'b0, pos_x};
        nextY = {1'b0, pos_y};
        case (dir)
            DIR_UP:    nextY = {1'b0, pos_y} - STEP_Y;
            DIR_DOWN:  nextY = {1'b0, pos_y} + STEP_Y;
            DIR_LEFT:  nextX = {1'b0, pos_x} - STEP_X;
            DIR_RIGHT: nextX = {1'b0, pos_x} + STEP_X;
            default:   ;
        endcase
        reject = (nextX > LIM_X) || (nextY > LIM_Y);
    end

    corner_addr #(.SIZE(SIZE)) uCorner (
        .candX (candX),
        .candY (candY),
        .k     (k),
        .cx    (wall_cx),
        .cy    (wall_cy)
    );

    // Move FSM; owns position, request and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            dir          <= DIR_UP;
            k            <= 2'd0;
            candX        <= 10'(START_X);
            candY        <= 9'(START_Y);
            pos_x        <= 10'(START_X);
            pos_y        <= 9'(START_Y);
            busy         <= 1'b0;
            wall_req     <= 1'b0;
            overrun      <= 1'b0;
            goal_reached <= 1'b0;
        end else begin
            // busy covers CALC..COMMIT, so a tick on the COMMIT cycle counts.
            overrun <= tick & busy;
            case (state)
                ST_IDLE: begin
                    if (tick && !goal_reached && anyBtn) begin
                        dir   <= pickDir(btn_up, btn_down, btn_left, btn_right);
                        busy  <= 1'b1;
                        state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (reject) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        candX    <= nextX[9:0];
                        candY    <= nextY[8:0];
                        k        <= 2'd0;
                        wall_req <= 1'b1;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Address comes from candX/candY/k, all frozen here.
                    if (wall_gnt) begin
                        wall_req <= 1'b0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wall_valid) begin
                        if (wall_hit) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else if (k != 2'd3) begin
                            k        <= k + 2'd1;
                            wall_req <= 1'b1;
                            state    <= ST_REQ;
                        end else begin
                            state <= ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    pos_x <= candX;
                    pos_y <= candY;
                    if ((candX >> CELL_SHIFT) == GOAL_X && (candY >> CELL_SHIFT) == GOAL_Y)
                        goal_reached <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy     <= 1'b0;
                    wall_req <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a behavioural wall-map arbiter.
module tb_move_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       btn_up = 1'b1, btn_down = 1'b1, btn_left = 1'b1, btn_right = 1'b1;
    logic       wall_gnt = 1'b0, wall_valid = 1'b0, wall_hit = 1'b0;
    logic       wall_req;
    logic [5:0] wall_cx;
    logic [4:0] wall_cy;
    logic [9:0] pos_x;
    logic [8:0] pos_y;
    logic       busy, overrun, goal_reached;

    localparam logic [3:0] B_UP     = 4'b0111;
    localparam logic [3:0] B_DOWN   = 4'b1011;
    localparam logic [3:0] B_LEFT   = 4'b1101;
    localparam logic [3:0] B_RIGHT  = 4'b1110;
    localparam logic [3:0] B_UPLEFT = 4'b0101;

    int vectors = 0, miscompares = 0;
    int reqCount = 0, overrunCount = 0, gntDelay = 0, waitCnt = 0;
    bit pendingValid = 0, addrBad = 0, reqSeen = 0;
    logic [5:0] capX = '0, holdX = '0;
    logic [4:0] capY = '0, holdY = '0;
    bit wallMap [64][32];

    move_sequencer dut (
        .clk(clk), .rst(rst), .tick(tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .wall_req(wall_req), .wall_cx(wall_cx), .wall_cy(wall_cy),
        .wall_gnt(wall_gnt), .wall_valid(wall_valid), .wall_hit(wall_hit),
        .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .overrun(overrun),
        .goal_reached(goal_reached)
    );

    always #5 clk = ~clk;

    // Arbiter + map: grant after gntDelay waiting cycles, data one cycle later.
    always @(negedge clk) begin
        wall_gnt   = 1'b0;
        wall_valid = 1'b0;
        if (overrun === 1'b1) overrunCount++;
        if (pendingValid) begin
            wall_valid   = 1'b1;
            wall_hit     = wallMap[capX][capY];
            pendingValid = 0;
        end
        if (wall_req === 1'b1) begin
            if (!reqSeen) begin
                holdX   = wall_cx;
                holdY   = wall_cy;
                reqSeen = 1;
            end else if (wall_cx !== holdX || wall_cy !== holdY) begin
                addrBad = 1;
            end
            if (waitCnt >= gntDelay) begin
                wall_gnt     = 1'b1;
                capX         = wall_cx;
                capY         = wall_cy;
                pendingValid = 1;
                reqCount++;
                waitCnt      = 0;
            end else begin
                waitCnt++;
            end
        end else begin
            reqSeen = 0;
            waitCnt = 0;
        end
    end

    task automatic cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic pulse(input logic [3:0] b);
        {btn_up, btn_down, btn_left, btn_right} = b;
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = 4'hF;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy !== 1'b0 && n < 500) begin
            cycle();
            n++;
        end
        if (n >= 500) check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic move(input logic [3:0] b);
        reqCount = 0;
        pulse(b);
        waitIdle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 32; j++)
                wallMap[i][j] = 0;

        // Reset state
        doReset();
        check("rst_pos_x", 32'(pos_x), 30);
        check("rst_pos_y", 32'(pos_y), 449);
        check("rst_busy", 32'(busy), 0);
        check("rst_wall_req", 32'(wall_req), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_goal", 32'(goal_reached), 0);

        // 1: right move on empty map, 11-cycle latency, 4 lookups
        reqCount = 0;
        pulse(B_RIGHT);
        repeat (9) cycle();
        check("lat_before", 32'(pos_x), 30);
        cycle();
        check("lat_at11_x", 32'(pos_x), 34);
        check("t1_pos_y", 32'(pos_y), 449);
        check("t1_busy", 32'(busy), 0);
        check("t1_reqs", 32'(reqCount), 4);

        // 2: wall at first corner aborts after one lookup
        doReset();
        wallMap[2][28] = 1;
        move(B_RIGHT);
        check("t2_pos_x", 32'(pos_x), 30);
        check("t2_reqs", 32'(reqCount), 1);
        check("t2_busy", 32'(busy), 0);
        wallMap[2][28] = 0;

        // 4: up beats left
        move(B_UPLEFT);
        check("t4_pos_y", 32'(pos_y), 445);
        check("t4_pos_x", 32'(pos_x), 30);

        // Left underflow: 30 -> 2, then reject
        for (int i = 0; i < 7; i++) move(B_LEFT);
        check("left_to_2", 32'(pos_x), 2);
        move(B_LEFT);
        check("left_uflow_x", 32'(pos_x), 2);
        check("left_uflow_reqs", 32'(reqCount), 0);
        for (int i = 0; i < 7; i++) move(B_RIGHT);
        check("right_back", 32'(pos_x), 30);

        // Down overflow: 445 -> 461, then 465 > Y_MAX rejected
        for (int i = 0; i < 4; i++) move(B_DOWN);
        check("down_to_461", 32'(pos_y), 461);
        move(B_DOWN);
        check("down_oflow_y", 32'(pos_y), 461);
        check("down_oflow_reqs", 32'(reqCount), 0);

        // 3: up underflow at pos_y=1
        for (int i = 0; i < 115; i++) move(B_UP);
        check("up_to_1", 32'(pos_y), 1);
        move(B_UP);
        check("up_uflow_y", 32'(pos_y), 1);
        check("up_uflow_reqs", 32'(reqCount), 0);
        check("up_uflow_busy", 32'(busy), 0);

        // 5: slow grant, second tick while busy
        gntDelay = 5;
        overrunCount = 0;
        addrBad = 0;
        reqCount = 0;
        pulse(B_RIGHT);
        repeat (4) cycle();
        pulse(B_RIGHT);
        waitIdle();
        repeat (20) cycle();
        check("t5_pos_x", 32'(pos_x), 34);
        check("t5_overruns", 32'(overrunCount), 1);
        check("t5_addr_stable", {31'd0, addrBad}, 0);
        check("t5_reqs", 32'(reqCount), 4);
        gntDelay = 0;

        // 6: goal cell (38,1), X_MAX boundary on the way
        doReset();
        for (int i = 0; i < 148; i++) move(B_RIGHT);
        check("right_to_622", 32'(pos_x), 622);
        move(B_RIGHT);
        check("right_oflow_x", 32'(pos_x), 622);
        check("right_oflow_reqs", 32'(reqCount), 0);
        for (int i = 0; i < 3; i++) move(B_LEFT);
        for (int i = 0; i < 104; i++) move(B_UP);
        check("pre_goal_y", 32'(pos_y), 33);
        check("pre_goal_flag", 32'(goal_reached), 0);
        move(B_UP);
        check("goal_x", 32'(pos_x), 610);
        check("goal_y", 32'(pos_y), 29);
        check("goal_flag", 32'(goal_reached), 1);
        move(B_UP);
        check("frozen_y", 32'(pos_y), 29);
        check("frozen_reqs", 32'(reqCount), 0);
        check("frozen_busy", 32'(busy), 0);
        doReset();
        check("rst2_pos_x", 32'(pos_x), 30);
        check("rst2_pos_y", 32'(pos_y), 449);
        check("rst2_goal", 32'(goal_reached), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
